// File: rtl/novacore_clk_pkg.sv
// Shared definitions for the NovaCORE core-clock stepper: register map,
// CTRL bit positions and FSM state encoding.
package novacore_clk_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_COUNT  = 2'd1;
  localparam logic [1:0] ADDR_HALF   = 2'd2;
  localparam logic [1:0] ADDR_ISSUED = 2'd3;

  // CTRL write bits
  localparam int CTRL_START    = 0;
  localparam int CTRL_ABORT    = 1;
  localparam int CTRL_FREE_RUN = 2;

  // CTRL read bits
  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_FREE_RUN = 2;
  localparam int STAT_OUT      = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } stepper_state_e;

endpackage

// File: rtl/novacore_phase_timer.sv
// Loadable down-counter with zero flag; times both HIGH and LOW phases of c_clk.
module novacore_phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && !zero) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/novacore_clk_stepper.sv
// Avalon-MM slave generating a programmed number of c_clk pulses (or free-run)
// with a programmable half-period; out_port comes straight from a flop.
module novacore_clk_stepper
  import novacore_clk_pkg::*;
#(
  parameter int HALF_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port
);

  // Bus: a write takes effect on the clk edge where chipselect=1 and write_n=0;
  // no wait states, reads are combinational from address.
  stepper_state_e    state_q, state_d;
  logic              out_q;
  logic [CNT_W-1:0]  count_q;
  logic [HALF_W-1:0] half_q;
  logic [HALF_W-1:0] half_m1;
  logic              free_run_q;
  logic              done_q;
  logic [CNT_W-1:0]  issued_q;
  logic              abort_pend_q;

  logic wr_en, ctrl_wr, start_req, abort_req, busy;
  logic tmr_load, tmr_zero;
  logic launch, zero_start, pulse_done, finish;

  assign wr_en     = chipselect && !write_n;
  assign ctrl_wr   = wr_en && (address == ADDR_CTRL);
  assign start_req = ctrl_wr && writedata[CTRL_START];
  assign abort_req = ctrl_wr && writedata[CTRL_ABORT];
  assign busy      = (state_q != ST_IDLE);
  assign half_m1   = (half_q == '0) ? '0 : half_q - HALF_W'(1);

  novacore_phase_timer #(.W(HALF_W)) u_phase_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (half_m1),
    .dec      (busy),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // A START write launches with the FREE_RUN value carried in the same write.
  always_comb begin
    state_d    = state_q;
    tmr_load   = 1'b0;
    launch     = 1'b0;
    zero_start = 1'b0;
    pulse_done = 1'b0;
    finish     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          if (count_q != '0 || writedata[CTRL_FREE_RUN]) begin
            state_d  = ST_HIGH;
            tmr_load = 1'b1;
            launch   = 1'b1;
          end else begin
            zero_start = 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (tmr_zero) begin
          state_d  = ST_LOW;
          tmr_load = 1'b1;
        end
      end
      ST_LOW: begin
        if (tmr_zero) begin
          pulse_done = 1'b1;
          if (abort_pend_q || (!free_run_q && count_q <= CNT_W'(1))) begin
            state_d = ST_IDLE;
            finish  = 1'b1;
          end else begin
            state_d  = ST_HIGH;
            tmr_load = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q        <= 1'b0;
      count_q      <= '0;
      half_q       <= HALF_W'(1);
      free_run_q   <= 1'b0;
      done_q       <= 1'b0;
      issued_q     <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      out_q <= (state_d == ST_HIGH);
      if (wr_en && address == ADDR_COUNT && !busy) begin
        count_q <= writedata[CNT_W-1:0];
      end else if (pulse_done && !free_run_q && count_q != '0) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (wr_en && address == ADDR_HALF && !busy) half_q <= writedata[HALF_W-1:0];
      if (ctrl_wr) free_run_q <= writedata[CTRL_FREE_RUN];
      if (launch)                    done_q <= 1'b0;
      else if (zero_start || finish) done_q <= 1'b1;
      if (pulse_done) issued_q <= issued_q + CNT_W'(1);
      // START+ABORT from IDLE arms the abort so exactly one pulse is issued.
      if (finish)                             abort_pend_q <= 1'b0;
      else if (abort_req && (busy || launch)) abort_pend_q <= 1'b1;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[STAT_BUSY]     = busy;
        readdata[STAT_DONE]     = done_q;
        readdata[STAT_FREE_RUN] = free_run_q;
        readdata[STAT_OUT]      = out_q;
      end
      ADDR_COUNT:  readdata[CNT_W-1:0]  = count_q;
      ADDR_HALF:   readdata[HALF_W-1:0] = half_q;
      ADDR_ISSUED: readdata[CNT_W-1:0]  = issued_q;
      default:     readdata = '0;
    endcase
  end

  assign out_port = out_q;

endmodule

// File: tb/tb_novacore_clk_stepper.sv
// Bench for novacore_clk_stepper: per-cycle waveform and register checks
// against an arithmetic model of pulse trains.
module tb_novacore_clk_stepper;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        out_port;

  int total = 0;
  int bad   = 0;

  int unsigned m_half;
  int unsigned m_count;
  int unsigned m_issued;

  typedef struct {
    int          k;
    logic [1:0]  a;
    logic [31:0] d;
  } inj_t;
  inj_t inj_q[$];

  novacore_clk_stepper dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d = readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Entered on the first negedge after the START write edge (cycle k=1).
  // Expected: np pulses of H high + H low, then idle with DONE.
  task automatic watch(input int h, input int np, input bit free, input int unsigned c0);
    int hh;
    int span;
    int p;
    bit busy_e, out_e;
    logic [31:0] d, ctrl_exp, cnt_exp;
    inj_t it;
    hh   = (h == 0) ? 1 : h;
    span = 2 * hh * np;
    for (int k = 1; k <= span + 2; k++) begin
      busy_e   = (k <= span);
      out_e    = busy_e && (((k - 1) % (2 * hh)) < hh);
      ctrl_exp = {28'd0, out_e, free, !busy_e, busy_e};
      p = (k - 1) / (2 * hh);
      if (p > np) p = np;
      cnt_exp = free ? c0 : c0 - p;
      chk($sformatf("out_port k=%0d", k), {31'd0, out_port}, {31'd0, out_e});
      rd(2'd0, d);
      chk($sformatf("ctrl k=%0d", k), d, ctrl_exp);
      rd(2'd1, d);
      chk($sformatf("count k=%0d", k), d, cnt_exp);
      if (inj_q.size() > 0 && inj_q[0].k == k) begin
        it         = inj_q.pop_front();
        address    = it.a;
        writedata  = it.d;
        chipselect = 1'b1;
        write_n    = 1'b0;
      end
      @(negedge clk);
      write_n    = 1'b1;
      chipselect = 1'b0;
    end
    m_issued += np;
    if (!free) m_count = c0 - np;
    rd(2'd3, d);
    chk("issued", d, m_issued);
    rd(2'd2, d);
    chk("half", d, m_half);
  endtask

  task automatic burst(input int h, input int n);
    wr(2'd2, h);
    m_half = h;
    wr(2'd1, n);
    m_count = n;
    wr(2'd0, 32'h1);
    watch(h, n, 1'b0, n);
  endtask

  initial begin
    logic [31:0] d;
    int h, n;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    m_half     = 1;
    m_count    = 0;
    m_issued   = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    chk("rst out_port", {31'd0, out_port}, 32'd0);
    rd(2'd0, d); chk("rst ctrl", d, 32'd0);
    rd(2'd1, d); chk("rst count", d, 32'd0);
    rd(2'd2, d); chk("rst half", d, 32'd1);
    rd(2'd3, d); chk("rst issued", d, 32'd0);

    // START with COUNT=0: no pulse, DONE next cycle
    wr(2'd0, 32'h1);
    watch(1, 0, 1'b0, 0);

    burst(3, 2);
    burst(0, 1);

    for (int i = 0; i < 6; i++) begin
      h = $urandom_range(0, 4);
      n = $urandom_range(0, 3);
      burst(h, n);
    end

    // Free-run, abort in the first HIGH cycle of the third pulse
    wr(2'd2, 32'd2);
    m_half = 2;
    wr(2'd1, 32'd4);
    m_count = 4;
    wr(2'd0, 32'h4);
    inj_q.push_back('{9, 2'd0, 32'h6});
    wr(2'd0, 32'h5);
    watch(2, 3, 1'b1, 4);
    wr(2'd0, 32'h0);

    // COUNT/HALF/START writes while busy are ignored
    wr(2'd2, 32'd2);
    m_half = 2;
    wr(2'd1, 32'd5);
    inj_q.push_back('{2, 2'd1, 32'd9});
    inj_q.push_back('{3, 2'd2, 32'd7});
    inj_q.push_back('{4, 2'd0, 32'h1});
    wr(2'd0, 32'h1);
    watch(2, 5, 1'b0, 5);

    // Reset in the middle of a HIGH phase
    wr(2'd2, 32'd3);
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    chk("pre-rst out_port", {31'd0, out_port}, 32'd1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid-rst out_port", {31'd0, out_port}, 32'd0);
    rd(2'd0, d); chk("mid-rst ctrl", d, 32'd0);
    rd(2'd1, d); chk("mid-rst count", d, 32'd0);
    rd(2'd2, d); chk("mid-rst half", d, 32'd1);
    rd(2'd3, d); chk("mid-rst issued", d, 32'd0);
    @(negedge clk);
    reset_n    = 1'b1;
    chipselect = 1'b0;
    repeat (3) @(negedge clk);
    chk("post-rst out_port", {31'd0, out_port}, 32'd0);
    rd(2'd0, d); chk("post-rst ctrl", d, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/novacore_clk_stepper.md
Name: novacore_clk_stepper

Overview:
Avalon-MM slave that sequences the NovaCORE core clock (c_clk) under software control. It replaces a bare 1-bit PIO toggled by software with a hardware pulse generator. The generator issues a programmed number of clock pulses, or runs free, with a programmable half-period. Software can then single-step, burst or free-run the core, and poll completion over the system interconnect.

Parameters:
HALF_W, 16, width of half-period register (system clk cycles per c_clk phase)
CNT_W, 32, width of pulse-count and issued-pulse counters (max 32)

Ports:
clk  in  1  system clock; all logic on posedge
reset_n  in  1  asynchronous active-low reset
address  in  2  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, combinational from address (zero-wait)
out_port  out  1  generated core clock c_clk

Behaviour:
- Registers, written when chipselect && !write_n:
  - addr0 CTRL. Write: bit0 START, bit1 ABORT, bit2 FREE_RUN (stored). Read: bit0 BUSY, bit1 DONE, bit2 FREE_RUN, bit3 out_port; other bits 0.
  - addr1 COUNT. Write loads pulses to issue. Read returns remaining pulses.
  - addr2 HALF. Write loads the phase length. A value of 0 behaves as 1. Read returns the stored value zero-extended.
  - addr3 ISSUED. Read-only count of completed pulses since reset, wraps at 2^CNT_W. Writes ignored.
- Reset: state IDLE, out_port=0, COUNT=0, HALF=1, FREE_RUN=0, DONE=0, ISSUED=0, abort_pend=0, phase counter=0.
- FSM states IDLE, HIGH, LOW.
  - IDLE -> HIGH on START write when (COUNT!=0 or FREE_RUN). out_port=1 in the cycle after the write edge, so START-to-rising-edge latency is 1 clk. DONE clears and phase counter loads max(HALF,1)-1.
  - HIGH: out_port=1, phase counter decrements. At 0 -> LOW, reload the counter.
  - LOW: out_port=0. At phase counter 0 the pulse is complete: ISSUED+1, and COUNT-1 unless FREE_RUN. Then:
    - if abort_pend, or (!FREE_RUN and COUNT was 1) -> IDLE, DONE=1, abort_pend=0;
    - else -> HIGH, reload the counter.
- Each pulse is exactly H high + H low clk cycles, H=max(HALF,1). Duty cycle 50%, no glitches. out_port is driven straight from a register.
- START in IDLE with COUNT=0 and !FREE_RUN: no pulse. DONE=1 the next cycle, BUSY stays 0.
- While BUSY (state != IDLE):
  - writes to COUNT and HALF are ignored;
  - START is ignored;
  - FREE_RUN bit updates are accepted but only evaluated at the end of a LOW phase.
  - Clearing FREE_RUN mid-run makes the burst continue until COUNT reaches 0. If COUNT is already 0, the run stops at the end of the current pulse.
- ABORT while BUSY sets abort_pend. The current pulse always completes, so c_clk is never truncated. COUNT keeps its remaining value. ABORT in IDLE has no effect.
- START and ABORT in the same write: START is evaluated first. From IDLE this produces exactly one pulse.
- COUNT decrement saturates at 0 in FREE_RUN; COUNT is not decremented in FREE_RUN.
- Reset asserted mid-pulse: immediate return to reset values, out_port=0 asynchronously.
- readdata is unregistered: a read of COUNT in the same cycle as a decrement returns the pre-decrement value.

Decomposition:
- Shared package novacore_clk_pkg holds:
  - register address constants (ADDR_CTRL=0, ADDR_COUNT=1, ADDR_HALF=2, ADDR_ISSUED=3);
  - CTRL bit indices;
  - the FSM state enum.
- Optional sub-module novacore_phase_timer: loadable down-counter with a zero flag, reused for the HIGH and LOW phases. Everything else stays flat.

Test Plan:
- Reset -> out_port=0; reads return CTRL=0, COUNT=0, HALF=1, ISSUED=0.
- HALF=3, COUNT=2, START -> out_port rises 1 clk after the write. Pattern is 3 high / 3 low, twice. DONE=1 and BUSY=0 after cycle 12. ISSUED=2, COUNT=0.
- HALF=0, COUNT=1, START -> single pulse 1 high / 1 low. DONE set 2 cycles after the rise.
- FREE_RUN=1, HALF=2, START, then ABORT written mid-HIGH -> the current pulse completes with a full 2 low cycles, then IDLE. ISSUED equals the number of rising edges. COUNT is unchanged.
- COUNT=5, START, then a write of COUNT=9 and HALF=7 while BUSY -> writes ignored. Exactly 5 pulses at the original HALF; START while busy issues no extra pulses.
- COUNT=0, FREE_RUN=0, START -> no edge on out_port; DONE=1 next cycle. Separately, reset_n low mid-HIGH -> out_port=0 immediately and all registers return to reset values.
